// File: rtl/ioctl_dn_pkg.sv
// Shared types for the HPS download router: FSM state encoding and default download indices.
package ioctl_dn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROM,
    ST_CFG,
    ST_SKIP,
    ST_FINISH
  } dn_state_e;

  localparam int DEF_ROM_INDEX = 0;
  localparam int DEF_CFG_INDEX = 1;

endpackage

// File: rtl/ioctl_dn_router_if.sv
// HPS download bus in, per-region ROM write bus out; master = HPS side, slave = router.
interface ioctl_dn_router_if #(
  parameter int ADDR_W     = 25,
  parameter int NUM_REGION = 2
);
  logic                  ioctl_download;
  logic [7:0]            ioctl_index;
  logic                  ioctl_wr;
  logic [ADDR_W-1:0]     ioctl_addr;
  logic [7:0]            ioctl_dout;
  logic [NUM_REGION-1:0] rom_wr;
  logic [ADDR_W-1:0]     rom_addr;
  logic [7:0]            rom_data;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  rom_wr, rom_addr, rom_data
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output rom_wr, rom_addr, rom_data
  );
endinterface

// File: rtl/ioctl_cfg_shadow.sv
// Config shadow bank: loaded from the live config at session start, edited byte-wise,
// committed atomically so the core never sees a half-written config.
module ioctl_cfg_shadow #(
  parameter int ADDR_W    = 25,
  parameter int CFG_BYTES = 4
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic                   wr_en,
  input  logic                   commit,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [7:0]             data,
  output logic [CFG_BYTES*8-1:0] cfg,
  output logic                   cfg_valid
);

  logic [CFG_BYTES*8-1:0] shadow_q, shadow_d;
  logic [CFG_BYTES*8-1:0] cfg_q, cfg_d;
  logic                   cfg_valid_q, cfg_valid_d;

  always_comb begin
    shadow_d    = shadow_q;
    cfg_d       = cfg_q;
    cfg_valid_d = cfg_valid_q;
    if (load) begin
      shadow_d = cfg_q;
    end else if (wr_en) begin
      // addresses at or beyond CFG_BYTES match no byte and are dropped
      for (int i = 0; i < CFG_BYTES; i++) begin
        if (addr == ADDR_W'(i)) shadow_d[i*8 +: 8] = data;
      end
    end
    if (commit) begin
      cfg_d       = shadow_q;
      cfg_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q    <= '0;
      cfg_q       <= '0;
      cfg_valid_q <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      cfg_q       <= cfg_d;
      cfg_valid_q <= cfg_valid_d;
    end
  end

  assign cfg       = cfg_q;
  assign cfg_valid = cfg_valid_q;

endmodule

// File: rtl/ioctl_dn_router.sv
// Routes HPS ioctl downloads to per-region ROM write strobes or a committed config bank.
// Optional running byte checksum of ROM strobes when DN_CHECKSUM_EN is defined.
module ioctl_dn_router
  import ioctl_dn_pkg::*;
#(
  parameter int ADDR_W      = 25,
  parameter int NUM_REGION  = 2,
  parameter int REGION_LOG2 = 16,
  parameter int CFG_BYTES   = 4,
  parameter int ROM_INDEX   = DEF_ROM_INDEX,
  parameter int CFG_INDEX   = DEF_CFG_INDEX
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  ioctl_dn_router_if.slave       bus,
  output logic [CFG_BYTES*8-1:0] cfg,
  output logic                   cfg_valid,
  output logic                   dn_busy,
  output logic                   dn_done,
  output logic                   dn_err
`ifdef DN_CHECKSUM_EN
  ,
  output logic [7:0]             checksum
`endif
);

  localparam int RW = ADDR_W - REGION_LOG2;

  dn_state_e             state_q, state_d;
  dn_state_e             sess_q, sess_d;
  logic [NUM_REGION-1:0] rom_wr_q, rom_wr_d;
  logic [ADDR_W-1:0]     rom_addr_q, rom_addr_d;
  logic [7:0]            rom_data_q, rom_data_d;
  logic                  dn_err_q, dn_err_d;
  logic [RW-1:0]         region;
  logic                  rom_entry;

  assign region = bus.ioctl_addr[ADDR_W-1:REGION_LOG2];

  // session type is latched on entry so index changes mid-session are ignored
  always_comb begin
    state_d = state_q;
    sess_d  = sess_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.ioctl_download) begin
          if (bus.ioctl_index == 8'(ROM_INDEX))      state_d = ST_ROM;
          else if (bus.ioctl_index == 8'(CFG_INDEX)) state_d = ST_CFG;
          else                                       state_d = ST_SKIP;
          sess_d = state_d;
        end
      end
      ST_ROM, ST_CFG, ST_SKIP: begin
        if (!bus.ioctl_download) state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign rom_entry = (state_q == ST_IDLE) && (state_d == ST_ROM);

  always_comb begin
    rom_wr_d   = '0;
    rom_addr_d = rom_addr_q;
    rom_data_d = rom_data_q;
    dn_err_d   = dn_err_q;
    if (rom_entry) dn_err_d = 1'b0;
    if (state_q == ST_ROM && bus.ioctl_wr) begin
      if (region < RW'(NUM_REGION)) begin
        for (int i = 0; i < NUM_REGION; i++) begin
          rom_wr_d[i] = (region == RW'(i));
        end
        rom_addr_d = ADDR_W'(bus.ioctl_addr[REGION_LOG2-1:0]);
        rom_data_d = bus.ioctl_dout;
      end else begin
        dn_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      sess_q     <= ST_IDLE;
      rom_wr_q   <= '0;
      rom_addr_q <= '0;
      rom_data_q <= '0;
      dn_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sess_q     <= sess_d;
      rom_wr_q   <= rom_wr_d;
      rom_addr_q <= rom_addr_d;
      rom_data_q <= rom_data_d;
      dn_err_q   <= dn_err_d;
    end
  end

  ioctl_cfg_shadow #(
    .ADDR_W    (ADDR_W),
    .CFG_BYTES (CFG_BYTES)
  ) u_shadow (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .load      ((state_q == ST_IDLE) && (state_d == ST_CFG)),
    .wr_en     ((state_q == ST_CFG) && bus.ioctl_wr),
    .commit    ((state_q == ST_FINISH) && (sess_q == ST_CFG)),
    .addr      (bus.ioctl_addr),
    .data      (bus.ioctl_dout),
    .cfg       (cfg),
    .cfg_valid (cfg_valid)
  );

`ifdef DN_CHECKSUM_EN
  logic [7:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (rom_entry)      checksum_d = '0;
    else if (|rom_wr_q) checksum_d = checksum_q + rom_data_q;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) checksum_q <= '0;
    else          checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

  assign bus.rom_wr   = rom_wr_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.rom_data = rom_data_q;
  assign dn_err       = dn_err_q;
  assign dn_done      = (state_q == ST_FINISH);
  assign dn_busy      = (state_q == ST_ROM) || ((state_q == ST_FINISH) && (sess_q == ST_ROM));

endmodule

// File: tb/tb_ioctl_dn_router.sv
// Directed bench for ioctl_dn_router: session-level reference model compared every cycle,
// plus literal expectations at the key points of each scenario.
module tb_ioctl_dn_router;

  localparam int ADDR_W      = 25;
  localparam int NUM_REGION  = 2;
  localparam int REGION_LOG2 = 16;
  localparam int CFG_BYTES   = 4;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  ioctl_dn_router_if #(.ADDR_W(ADDR_W), .NUM_REGION(NUM_REGION)) bus ();

  logic [CFG_BYTES*8-1:0] cfg;
  logic                   cfg_valid, dn_busy, dn_done, dn_err;
`ifdef DN_CHECKSUM_EN
  logic [7:0]             checksum;
`endif

  ioctl_dn_router #(
    .ADDR_W      (ADDR_W),
    .NUM_REGION  (NUM_REGION),
    .REGION_LOG2 (REGION_LOG2),
    .CFG_BYTES   (CFG_BYTES),
    .ROM_INDEX   (0),
    .CFG_INDEX   (1)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .cfg       (cfg),
    .cfg_valid (cfg_valid),
    .dn_busy   (dn_busy),
    .dn_done   (dn_done),
    .dn_err    (dn_err)
`ifdef DN_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: session kind 0=none 1=rom 2=cfg 3=skip, fin marks the closing cycle.
  int                     m_kind = 0;
  bit                     m_fin  = 1'b0;
  logic [NUM_REGION-1:0]  m_wr   = '0;
  logic [ADDR_W-1:0]      m_addr = '0;
  logic [7:0]             m_data = '0;
  logic [7:0]             m_csum = '0;
  logic [CFG_BYTES*8-1:0] m_cfg  = '0;
  bit                     m_valid = 1'b0;
  bit                     m_err   = 1'b0;
  int                     pend_a[$];
  logic [7:0]             pend_d[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_kind = 0; m_fin = 1'b0; m_wr = '0; m_addr = '0; m_data = '0; m_csum = '0;
    m_cfg = '0; m_valid = 1'b0; m_err = 1'b0;
    pend_a.delete(); pend_d.delete();
  endtask

  // One clock edge of the download protocol, applied at the session level.
  task automatic model_step();
    int a, r;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (m_wr != '0) m_csum = m_csum + m_data;
    m_wr = '0;
    a = int'(bus.ioctl_addr);
    if (m_fin) begin
      if (m_kind == 2) begin
        foreach (pend_a[k]) m_cfg[pend_a[k]*8 +: 8] = pend_d[k];
        m_valid = 1'b1;
      end
      m_fin = 1'b0;
      m_kind = 0;
    end else if (m_kind == 0) begin
      if (bus.ioctl_download) begin
        m_kind = (bus.ioctl_index == 8'd0) ? 1 : (bus.ioctl_index == 8'd1) ? 2 : 3;
        if (m_kind == 1) begin
          m_err = 1'b0;
          m_csum = '0;
        end
        pend_a.delete(); pend_d.delete();
      end
    end else begin
      if (bus.ioctl_wr && m_kind == 1) begin
        r = a / (1 << REGION_LOG2);
        if (r < NUM_REGION) begin
          m_wr   = NUM_REGION'(1 << r);
          m_addr = ADDR_W'(a % (1 << REGION_LOG2));
          m_data = bus.ioctl_dout;
        end else begin
          m_err = 1'b1;
        end
      end else if (bus.ioctl_wr && m_kind == 2 && a < CFG_BYTES) begin
        pend_a.push_back(a);
        pend_d.push_back(bus.ioctl_dout);
      end
      if (!bus.ioctl_download) m_fin = 1'b1;
    end
  endtask

  task automatic step(input bit dl, input int idx, input bit wr, input int addr, input logic [7:0] d);
    bus.ioctl_download = dl;
    bus.ioctl_index    = 8'(idx);
    bus.ioctl_wr       = wr;
    bus.ioctl_addr     = ADDR_W'(addr);
    bus.ioctl_dout     = d;
    @(posedge clk_sys);
    model_step();
    @(negedge clk_sys);
  endtask

  initial begin
    @(posedge clk_sys);
    forever begin
      @(negedge clk_sys);
      check("rom_wr",    64'(bus.rom_wr),   64'(m_wr));
      check("rom_addr",  64'(bus.rom_addr), 64'(m_addr));
      check("rom_data",  64'(bus.rom_data), 64'(m_data));
      check("cfg",       64'(cfg),          64'(m_cfg));
      check("cfg_valid", 64'(cfg_valid),    64'(m_valid));
      check("dn_busy",   64'(dn_busy),      64'(m_kind == 1));
      check("dn_done",   64'(dn_done),      64'(m_fin));
      check("dn_err",    64'(dn_err),       64'(m_err));
`ifdef DN_CHECKSUM_EN
      check("checksum",  64'(checksum),     64'(m_csum));
`endif
    end
  end

  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = '0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    repeat (2) step(0, 0, 0, 0, 8'h00);
    reset_n = 1'b1;
    check("rst_cfg",   64'(cfg),       64'h0);
    check("rst_valid", 64'(cfg_valid), 64'h0);
    check("rst_busy",  64'(dn_busy),   64'h0);
    check("rst_err",   64'(dn_err),    64'h0);
    check("rst_romwr", 64'(bus.rom_wr), 64'h0);

    // ROM session into both regions
    step(1, 0, 0, 0, 8'h00);
    check("rom_busy_in", 64'(dn_busy), 64'h1);
    step(1, 0, 1, 'h00000, 8'hA5);
    check("wr0_strobe", 64'(bus.rom_wr),   64'h1);
    check("wr0_addr",   64'(bus.rom_addr), 64'h0);
    check("wr0_data",   64'(bus.rom_data), 64'hA5);
    step(1, 0, 1, 'h1FFFF, 8'h3C);
    check("wr1_strobe", 64'(bus.rom_wr),   64'h2);
    check("wr1_addr",   64'(bus.rom_addr), 64'hFFFF);
    check("wr1_data",   64'(bus.rom_data), 64'h3C);
    step(1, 0, 0, 0, 8'h00);
    check("strobe_1cyc", 64'(bus.rom_wr), 64'h0);
    step(0, 0, 0, 0, 8'h00);
    check("fin_busy", 64'(dn_busy), 64'h1);
    check("fin_done", 64'(dn_done), 64'h1);
    step(0, 0, 0, 0, 8'h00);
    check("idle_busy", 64'(dn_busy), 64'h0);
    check("idle_done", 64'(dn_done), 64'h0);

    // out-of-range region sets a sticky error
    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 1, 'h20000, 8'h55);
    check("oor_strobe", 64'(bus.rom_wr), 64'h0);
    check("oor_err",    64'(dn_err),     64'h1);
    repeat (3) step(0, 0, 0, 0, 8'h00);
    check("err_sticky", 64'(dn_err), 64'h1);
    step(1, 0, 0, 0, 8'h00);
    check("err_clear", 64'(dn_err), 64'h0);
    repeat (2) step(0, 0, 0, 0, 8'h00);

    // CFG session: addr 5 is outside the bank
    step(1, 1, 0, 0, 8'h00);
    step(1, 1, 1, 0, 8'h12);
    step(1, 1, 1, 5, 8'hFF);
    check("cfg_hold", 64'(cfg), 64'h0);
    step(0, 1, 0, 0, 8'h00);
    check("cfg_fin_hold", 64'(cfg), 64'h0);
    step(0, 1, 0, 0, 8'h00);
    check("cfg_commit", 64'(cfg),       64'h0000_0012);
    check("cfg_valid1", 64'(cfg_valid), 64'h1);

    // second CFG session, index changes mid-session
    step(1, 1, 0, 0, 8'h00);
    step(1, 0, 1, 2, 8'h77);
    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    check("cfg_merge", 64'(cfg), 64'h0077_0012);

    // ROM session with a write on the download fall
    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 1, 'h00010, 8'hFF);
    step(0, 0, 1, 'h10011, 8'h02);
    check("fall_strobe", 64'(bus.rom_wr),   64'h2);
    check("fall_addr",   64'(bus.rom_addr), 64'h11);
    check("fall_data",   64'(bus.rom_data), 64'h02);
    step(0, 0, 0, 0, 8'h00);
    check("rom_keeps_cfg", 64'(cfg), 64'h0077_0012);
`ifdef DN_CHECKSUM_EN
    check("csum_wrap", 64'(checksum), 64'h01);
`endif

    // reset mid ROM session, download stays high across release
    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 1, 'h3, 8'h11);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_romwr", 64'(bus.rom_wr),   64'h0);
    check("mid_rst_addr",  64'(bus.rom_addr), 64'h0);
    check("mid_rst_data",  64'(bus.rom_data), 64'h0);
    check("mid_rst_cfg",   64'(cfg),          64'h0);
    check("mid_rst_valid", 64'(cfg_valid),    64'h0);
    check("mid_rst_busy",  64'(dn_busy),      64'h0);
    check("mid_rst_done",  64'(dn_done),      64'h0);
    @(negedge clk_sys);
    repeat (2) step(1, 0, 0, 0, 8'h00);
    check("rst_no_done", 64'(dn_done), 64'h0);
    reset_n = 1'b1;
    step(1, 0, 0, 0, 8'h00);
    check("resync_busy", 64'(dn_busy), 64'h1);
    repeat (2) step(0, 0, 0, 0, 8'h00);

    // unknown index goes to SKIP
    step(1, 7, 0, 0, 8'h00);
    step(1, 7, 1, 0, 8'h99);
    check("skip_strobe", 64'(bus.rom_wr), 64'h0);
    check("skip_busy",   64'(dn_busy),    64'h0);
    step(0, 7, 0, 0, 8'h00);
    check("skip_done", 64'(dn_done), 64'h1);
    step(0, 7, 0, 0, 8'h00);
    check("skip_done_end", 64'(dn_done), 64'h0);
    check("skip_romwr",    64'(bus.rom_wr), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ioctl_dn_router.md
IOCTL_DN_ROUTER -- requirements
Module: ioctl_dn_router

Interface
REQ-001 SHALL have parameter ADDR_W, default 25: width of ioctl_addr and rom_addr.
REQ-002 SHALL have parameter NUM_REGION, default 2: number of ROM regions, range 1..8.
REQ-003 SHALL have parameter REGION_LOG2, default 16: region size is 2^REGION_LOG2 bytes.
REQ-004 SHALL have parameter CFG_BYTES, default 4: number of captured config bytes, range 1..16.
REQ-005 SHALL have parameter ROM_INDEX, default 0, and CFG_INDEX, default 1: the ioctl_index values for ROM and config downloads.
REQ-006 SHALL have port clk_sys, input, 1 bit: sole clock, rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have inputs ioctl_download (1), ioctl_index (8), ioctl_wr (1), ioctl_addr (ADDR_W) and ioctl_dout (8): the HPS download bus.
REQ-009 SHALL have outputs rom_wr (NUM_REGION), rom_addr (ADDR_W) and rom_data (8): per-region write strobe, region-local address and data.
REQ-010 SHALL have outputs cfg (CFG_BYTES*8) and cfg_valid (1): committed config bytes, with byte 0 at bits [7:0].
REQ-011 SHALL have outputs dn_busy (1), dn_done (1) and dn_err (1): core-hold signal, end-of-session pulse and sticky range error.

Function
REQ-012 SHALL implement the states IDLE, ROM, CFG, SKIP and FINISH.
REQ-013 SHALL leave IDLE only on ioctl_download=1, going to ROM if ioctl_index==ROM_INDEX, to CFG if ioctl_index==CFG_INDEX, and to SKIP otherwise.
REQ-014 SHALL move from ROM, CFG or SKIP to FINISH on the cycle ioctl_download=0, and from FINISH to IDLE unconditionally after one cycle.
REQ-015 SHALL compute the region in ROM state as r = ioctl_addr[ADDR_W-1:REGION_LOG2].
REQ-016 SHALL, for each ioctl_wr with r<NUM_REGION in ROM state, pulse rom_wr[r] for exactly one cycle one cycle later, with rom_addr = ioctl_addr[REGION_LOG2-1:0] zero-extended and rom_data = ioctl_dout.
REQ-017 SHALL, for each ioctl_wr in ROM state with r>=NUM_REGION, produce no strobe and set dn_err; dn_err SHALL stay set until the next entry into ROM state.
REQ-018 SHALL load a shadow bank from cfg on entry to CFG state.
REQ-019 SHALL, in CFG state, write ioctl_dout into shadow byte ioctl_addr on each ioctl_wr with ioctl_addr<CFG_BYTES, and silently ignore higher addresses.
REQ-020 SHALL copy the shadow bank into cfg and set cfg_valid in FINISH only when the session was CFG; shadow bytes not written keep their prior cfg values.
REQ-021 SHALL keep cfg and cfg_valid unchanged by ROM or SKIP sessions; cfg_valid clears only on reset.
REQ-022 SHALL hold dn_busy=1 in ROM and FINISH after a ROM session, and 0 otherwise.
REQ-023 SHALL pulse dn_done for one cycle in FINISH for every session type.
REQ-024 SHALL process an ioctl_wr arriving in the same cycle as the ioctl_download fall before leaving the session.
REQ-025 SHALL ignore ioctl_wr in IDLE and SKIP.
REQ-026 SHALL ignore a change of ioctl_index during a session.

Reset
REQ-027 SHALL, while reset_n=0, force state IDLE, rom_wr=0, rom_addr=0, rom_data=0, cfg=0, cfg_valid=0, dn_busy=0, dn_done=0, dn_err=0 and shadow=0, asynchronously.
REQ-028 SHALL, after reset asserts mid-session, re-sync only on the next ioctl_download rising from IDLE; an ongoing download is treated as a new session if still high.

Configuration
REQ-029 SHALL, with DN_CHECKSUM_EN defined, provide output checksum (8): the modulo-256 sum of all bytes strobed by rom_wr in the current ROM session, cleared on ROM entry, updated one cycle after each strobe, held otherwise, and reset to 0.
REQ-030 SHALL, without DN_CHECKSUM_EN defined, omit the checksum port and its logic entirely.

Structure
REQ-031 SHALL place the state enum and the default ROM_INDEX/CFG_INDEX constants in package ioctl_dn_pkg.
REQ-032 SHALL implement the shadow bank and commit as sub-module ioctl_cfg_shadow.

Verification
REQ-033 SHALL cover: ROM session, writes to addr 0x00000 (data 0xA5) and 0x1FFFF (data 0x3C) -> rom_wr=01, rom_addr=0 and then rom_wr=10, rom_addr=0xFFFF, one cycle after each ioctl_wr; dn_busy=1 through FINISH; one dn_done pulse.
REQ-034 SHALL cover: ROM write at 0x20000 with NUM_REGION=2 -> no rom_wr and dn_err=1, which stays 1 through IDLE and clears on the next ROM entry.
REQ-035 SHALL cover: CFG session writing addr 0=0x12 and addr 5=0xFF -> cfg unchanged until FINISH, then cfg=0x00000012 and cfg_valid=1; addr 5 ignored.
REQ-036 SHALL cover: a second CFG session writing only addr 2=0x77 -> cfg=0x00770012.
REQ-037 SHALL cover: reset_n pulsed low mid-ROM session -> all outputs 0 in the same cycle, with no dn_done; an index-7 session -> SKIP with no strobes and a dn_done pulse.
REQ-038 SHALL cover, with DN_CHECKSUM_EN: bytes 0xFF, 0x02 -> checksum=0x01.
